// File: rtl/coef_load_ctrl_pkg.sv
// Shared constants and FSM encoding for the coefficient reload path
// (key block, coefficient ROM, FIR coefficient bank and coef_load_ctrl).
package coef_load_ctrl_pkg;

  localparam int DEF_TAP_NUM    = 16;
  localparam int DEF_COEF_WIDTH = 16;
  localparam int DEF_SET_BITS   = 2;

  // The key block powers up selecting this set, so the loader fetches it unasked.
  localparam int BOOT_SET = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/coef_load_ctrl.sv
// Streams one coefficient set from the external ROM into the FIR coefficient
// bank, one tap per cycle, with a single-deep "newest request wins" pending slot.
module coef_load_ctrl
  import coef_load_ctrl_pkg::*;
#(
  parameter int TAP_NUM    = DEF_TAP_NUM,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int SET_BITS   = DEF_SET_BITS,
  localparam int TAP_BITS  = $clog2(TAP_NUM),
  localparam int ADDR_BITS = SET_BITS + TAP_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_req,
  input  logic [SET_BITS-1:0]   src_coef_idx,
  output logic                  rom_rd_en,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_data,
  output logic                  coef_wr_en,
  output logic [TAP_BITS-1:0]   coef_wr_addr,
  output logic [COEF_WIDTH-1:0] coef_wr_data,
  output logic                  coef_busy,
  output logic                  coef_done,
  output logic [SET_BITS-1:0]   coef_set_active
);

  localparam logic [TAP_BITS-1:0] TAP_LAST  = TAP_BITS'(TAP_NUM - 1);
  localparam logic [TAP_BITS-1:0] TAP_ONE   = TAP_BITS'(1);
  localparam logic [TAP_BITS-1:0] TAP_ZERO  = '0;
  localparam logic [SET_BITS-1:0] BOOT_IDX  = SET_BITS'(BOOT_SET);

  load_state_t          state;
  logic [SET_BITS-1:0]  load_idx;
  logic [TAP_BITS-1:0]  tap_cnt;
  logic [TAP_BITS-1:0]  tap_nxt;
  logic                 pend;
  logic [SET_BITS-1:0]  pend_idx;
  logic                 boot;

  logic                 start_now;
  logic [SET_BITS-1:0]  start_idx;

  assign tap_nxt = tap_cnt + TAP_ONE;

  // A load starts from IDLE (external or power-up request) or straight out of
  // DONE when a request is pending or arrives in that very cycle.
  always_comb begin
    start_now = 1'b0;
    start_idx = src_coef_idx;
    unique case (state)
      ST_IDLE: begin
        start_now = src_req || boot;
        start_idx = boot ? BOOT_IDX : src_coef_idx;
      end
      ST_DONE: begin
        start_now = src_req || pend;
        start_idx = src_req ? src_coef_idx : pend_idx;
      end
      default: ;
    endcase
  end

  // ---- stage p0: sequencer and ROM read issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      load_idx        <= '0;
      tap_cnt         <= '0;
      pend            <= 1'b0;
      pend_idx        <= '0;
      boot            <= 1'b1;
      rom_rd_en       <= 1'b0;
      rom_addr        <= '0;
      coef_busy       <= 1'b0;
      coef_done       <= 1'b0;
      coef_set_active <= BOOT_IDX;
    end else begin
      coef_done <= 1'b0;

      if (state == ST_DONE)
        coef_set_active <= load_idx;

      if (start_now) begin
        state     <= ST_READ;
        load_idx  <= start_idx;
        tap_cnt   <= '0;
        rom_rd_en <= 1'b1;
        rom_addr  <= {start_idx, TAP_ZERO};
        coef_busy <= 1'b1;
        boot      <= 1'b0;
        // A user request colliding with the power-up load is kept for later.
        pend      <= (state == ST_IDLE) && boot && src_req;
        pend_idx  <= src_coef_idx;
      end else begin
        if (src_req && (state == ST_READ || state == ST_FLUSH)) begin
          pend     <= 1'b1;
          pend_idx <= src_coef_idx;
        end

        unique case (state)
          ST_READ: begin
            if (tap_cnt == TAP_LAST) begin
              state     <= ST_FLUSH;
              rom_rd_en <= 1'b0;
            end else begin
              tap_cnt  <= tap_nxt;
              rom_addr <= {load_idx, tap_nxt};
            end
          end
          ST_FLUSH: begin
            state     <= ST_DONE;
            coef_done <= 1'b1;
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            coef_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1: coefficient bank write, one cycle behind the ROM read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_wr_en   <= 1'b0;
      coef_wr_addr <= '0;
    end else begin
      coef_wr_en   <= rom_rd_en;
      coef_wr_addr <= rom_addr[TAP_BITS-1:0];
    end
  end

  // rom_data is already the ROM's output register, aligned with coef_wr_en;
  // gating keeps the data bus at zero whenever no write is in flight.
  assign coef_wr_data = coef_wr_en ? rom_data : '0;

endmodule
